button_debouncer_array: RTL and testbench

- Parametrised successor to the single-button debouncer.
- Debounces NUM_BTNS independent asynchronous button/switch inputs.
- Per channel, emits a stable level plus single-cycle press, release and long-press event pulses.
- Sits between board pins and the UI/control FSMs, so consumers never implement their own edge detection.

---
 rtl/button_debouncer_array_pkg.sv | 29 ++
 rtl/button_debouncer_array_if.sv | 21 ++
 rtl/button_debouncer_array_debounce_channel.sv | 139 +++++++++++++
 rtl/button_debouncer_array.sv | 62 ++++++
 tb/tb_button_debouncer_array.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/button_debouncer_array_pkg.sv
// Shared types and default cycle counts for the button debouncer array.
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE    = 2'd0,
    BTN_PRESSED = 2'd1,
    BTN_HELD    = 2'd2
  } btn_state_e;

  localparam int unsigned CLK_FREQ_HZ  = 100_000_000;
  localparam int unsigned DEB_20MS     = CLK_FREQ_HZ / 50;
  localparam int unsigned LONG_1S      = CLK_FREQ_HZ;
  localparam int unsigned REPEAT_200MS = CLK_FREQ_HZ / 5;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Hold counter doubles as the repeat counter when auto-repeat is built in.
  function automatic int hold_width(input int unsigned long_cycles,
                                    input int unsigned repeat_cycles,
                                    input bit          repeat_en);
    int unsigned span;
    span = (repeat_en && repeat_cycles > long_cycles) ? repeat_cycles : long_cycles;
    return cnt_width(span);
  endfunction

endpackage

// File: rtl/button_debouncer_array_if.sv
// Button pins in, debounced levels and event pulses out.
interface button_debouncer_array_if #(
  parameter int NUM_BTNS = 5
) ();
  logic [NUM_BTNS-1:0] btn_in;
  logic [NUM_BTNS-1:0] btn_level;
  logic [NUM_BTNS-1:0] press_pulse;
  logic [NUM_BTNS-1:0] release_pulse;
  logic [NUM_BTNS-1:0] long_pulse;
  logic                any_pressed;

  modport master (
    output btn_in,
    input  btn_level, press_pulse, release_pulse, long_pulse, any_pressed
  );

  modport slave (
    input  btn_in,
    output btn_level, press_pulse, release_pulse, long_pulse, any_pressed
  );
endinterface

// File: rtl/button_debouncer_array_debounce_channel.sv
// One button channel: 2-FF synchroniser, debounce counter, press/hold FSM.
// Auto-repeat in HELD is built only with BUTTON_DEBOUNCER_AUTOREPEAT_EN.
module debounce_channel
  import btn_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEB_20MS,
  parameter int unsigned LONG_CYCLES     = LONG_1S,
  parameter int unsigned REPEAT_CYCLES   = REPEAT_200MS,
  parameter logic        ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level_o,
  output logic level_next_o,
  output logic press_pulse_o,
  output logic release_pulse_o,
  output logic long_pulse_o
);

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
  localparam bit REPEAT_EN = 1'b1;
`else
  localparam bit REPEAT_EN = 1'b0;
`endif

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int HW = hold_width(LONG_CYCLES, REPEAT_CYCLES, REPEAT_EN);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);
`endif

  logic          sync0_q, sync0_d;
  logic          sync1_q, sync1_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          level_q, level_d;
  btn_state_e    state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;
  logic          rise, fall;

  always_comb begin
    sync0_d   = btn_raw ^ ACTIVE_LOW;
    sync1_d   = sync0_q;
    level_d   = level_q;
    deb_cnt_d = '0;
    // Any sample agreeing with the accepted level restarts qualification.
    if (sync1_q != level_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        level_d = sync1_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
    rise = level_d & ~level_q;
    fall = ~level_d & level_q;

    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    case (state_q)
      BTN_IDLE: begin
        if (rise) begin
          state_d    = BTN_PRESSED;
          press_d    = 1'b1;
          hold_cnt_d = '0;
        end
      end
      BTN_PRESSED: begin
        // A fall on the threshold cycle takes priority over the long press.
        if (fall) begin
          state_d   = BTN_IDLE;
          release_d = 1'b1;
        end else if (hold_cnt_q == LONG_LAST) begin
          state_d    = BTN_HELD;
          long_d     = 1'b1;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      BTN_HELD: begin
        if (fall) begin
          state_d   = BTN_IDLE;
          release_d = 1'b1;
        end
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
        else if (hold_cnt_q == REP_LAST) begin
          long_d     = 1'b1;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = BTN_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync0_q    <= 1'b0;
      sync1_q    <= 1'b0;
      deb_cnt_q  <= '0;
      level_q    <= 1'b0;
      state_q    <= BTN_IDLE;
      hold_cnt_q <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      sync0_q    <= sync0_d;
      sync1_q    <= sync1_d;
      deb_cnt_q  <= deb_cnt_d;
      level_q    <= level_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
    end
  end

  // During reset the next level is forced low so any_pressed clears with the rest.
  assign level_next_o    = reset ? 1'b0 : level_d;
  assign btn_level_o     = level_q;
  assign press_pulse_o   = press_q;
  assign release_pulse_o = release_q;
  assign long_pulse_o    = long_q;

endmodule

// File: rtl/button_debouncer_array.sv
// NUM_BTNS independent debounced button channels plus a registered any_pressed.
// Optional auto-repeat of long_pulse: define BUTTON_DEBOUNCER_AUTOREPEAT_EN.
module button_debouncer_array
  import btn_debounce_pkg::*;
#(
  parameter int                  NUM_BTNS        = 5,
  parameter int unsigned         DEBOUNCE_CYCLES = DEB_20MS,
  parameter int unsigned         LONG_CYCLES     = LONG_1S,
  parameter int unsigned         REPEAT_CYCLES   = REPEAT_200MS,
  parameter logic [NUM_BTNS-1:0] ACTIVE_LOW_MASK = {NUM_BTNS{1'b0}}
) (
  input logic                    clk,
  input logic                    reset,
  button_debouncer_array_if.slave bus
);

  logic [NUM_BTNS-1:0] level_next;
  logic [NUM_BTNS-1:0] level;
  logic [NUM_BTNS-1:0] press;
  logic [NUM_BTNS-1:0] release_evt;
  logic [NUM_BTNS-1:0] long_evt;
  logic                any_pressed_q, any_pressed_d;

  generate
    for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_ch
      debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .LONG_CYCLES     (LONG_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW_MASK[gi])
      ) u_ch (
        .clk             (clk),
        .reset           (reset),
        .btn_raw         (bus.btn_in[gi]),
        .btn_level_o     (level[gi]),
        .level_next_o    (level_next[gi]),
        .press_pulse_o   (press[gi]),
        .release_pulse_o (release_evt[gi]),
        .long_pulse_o    (long_evt[gi])
      );
    end
  endgenerate

  always_comb begin
    any_pressed_d = |level_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      any_pressed_q <= 1'b0;
    end else begin
      any_pressed_q <= any_pressed_d;
    end
  end

  assign bus.btn_level     = level;
  assign bus.press_pulse   = press;
  assign bus.release_pulse = release_evt;
  assign bus.long_pulse    = long_evt;
  assign bus.any_pressed   = any_pressed_q;

endmodule

// File: tb/tb_button_debouncer_array.sv
// Directed bench: vector table for press/hold/release, hand sequences for corner cases.
module tb_button_debouncer_array;

  localparam int NB = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  button_debouncer_array_if #(.NUM_BTNS(NB)) bus ();

  button_debouncer_array #(
    .NUM_BTNS        (NB),
    .DEBOUNCE_CYCLES (8),
    .LONG_CYCLES     (32),
    .REPEAT_CYCLES   (10),
    .ACTIVE_LOW_MASK (3'b100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [NB-1:0] acc_press, acc_rel, acc_long;

  typedef struct {
    logic [NB-1:0] btn;
    int            cyc;
    logic [NB-1:0] lvl;
    logic [NB-1:0] pr;
    logic [NB-1:0] rl;
    logic [NB-1:0] lg;
    logic          any;
    string         nm;
  } vec_t;

  vec_t vecs [10];

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_acc();
    acc_press = '0;
    acc_rel   = '0;
    acc_long  = '0;
  endtask

  task automatic step_acc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      acc_press |= bus.press_pulse;
      acc_rel   |= bus.release_pulse;
      acc_long  |= bus.long_pulse;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [NB-1:0] lvl, input logic [NB-1:0] pr,
                         input logic [NB-1:0] rl, input logic [NB-1:0] lg, input logic any);
    chk({nm, " level"},   32'(bus.btn_level),     32'(lvl));
    chk({nm, " press"},   32'(bus.press_pulse),   32'(pr));
    chk({nm, " release"}, 32'(bus.release_pulse), 32'(rl));
    chk({nm, " long"},    32'(bus.long_pulse),    32'(lg));
    chk({nm, " any"},     32'(bus.any_pressed),   32'(any));
    $display("check %-24s btn_in=%b level=%b press=%b rel=%b long=%b any=%b",
             nm, bus.btn_in, bus.btn_level, bus.press_pulse, bus.release_pulse,
             bus.long_pulse, bus.any_pressed);
  endtask

  task automatic chk_acc(input string nm, input logic [NB-1:0] pr,
                         input logic [NB-1:0] rl, input logic [NB-1:0] lg);
    chk({nm, " press seen"},   32'(acc_press), 32'(pr));
    chk({nm, " release seen"}, 32'(acc_rel),   32'(rl));
    chk({nm, " long seen"},    32'(acc_long),  32'(lg));
    $display("window %-23s press=%b rel=%b long=%b", nm, acc_press, acc_rel, acc_long);
  endtask

  initial begin
    // Cycle numbers are relative to the cycle ch0 is pressed (press at 0, release at 60).
    vecs[0] = '{3'b101,  9, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, "c9 qualifying"};
    vecs[1] = '{3'b101,  1, 3'b001, 3'b001, 3'b000, 3'b000, 1'b1, "c10 press"};
    vecs[2] = '{3'b101,  1, 3'b001, 3'b000, 3'b000, 3'b000, 1'b1, "c11 press done"};
    vecs[3] = '{3'b101, 30, 3'b001, 3'b000, 3'b000, 3'b000, 1'b1, "c41 before long"};
    vecs[4] = '{3'b101,  1, 3'b001, 3'b000, 3'b000, 3'b001, 1'b1, "c42 long"};
    vecs[5] = '{3'b101,  1, 3'b001, 3'b000, 3'b000, 3'b000, 1'b1, "c43 long done"};
    vecs[6] = '{3'b101, 17, 3'b001, 3'b000, 3'b000, 3'b000, 1'b1, "c60 held"};
    vecs[7] = '{3'b100,  9, 3'b001, 3'b000, 3'b000, 3'b000, 1'b1, "c69 still held"};
    vecs[8] = '{3'b100,  1, 3'b000, 3'b000, 3'b001, 3'b000, 1'b0, "c70 release"};
    vecs[9] = '{3'b100,  1, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, "c71 release done"};

    // Idle pattern: ch2 is active-low, so its pin idles high.
    bus.btn_in = 3'b100;
    reset = 1'b1;
    step(3);
    chk_out("reset state", 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
    reset = 1'b0;
    step(12);
    chk_out("idle ch2 pin high", 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);

    for (int i = 0; i < 10; i++) begin
      bus.btn_in = vecs[i].btn;
      step(vecs[i].cyc);
      chk_out(vecs[i].nm, vecs[i].lvl, vecs[i].pr, vecs[i].rl, vecs[i].lg, vecs[i].any);
    end
    step(5);

    // Bounce on ch1: 3-cycle runs never qualify; settle high at cycle 30.
    clr_acc();
    for (int c = 0; c < 30; c++) begin
      bus.btn_in = {1'b1, ((c / 3) % 2 == 0), 1'b0};
      step_acc(1);
    end
    bus.btn_in = 3'b110;
    step_acc(9);
    chk_acc("bounce c1..c39", 3'b000, 3'b000, 3'b000);
    chk("bounce level c39", 32'(bus.btn_level), 32'(3'b000));
    step(1);
    chk_out("bounce press c40", 3'b010, 3'b010, 3'b000, 3'b000, 1'b1);
    step(1);
    chk_out("bounce press done", 3'b010, 3'b000, 3'b000, 3'b000, 1'b1);
    bus.btn_in = 3'b100;
    step(10);
    chk_out("ch1 release", 3'b000, 3'b000, 3'b010, 3'b000, 1'b0);
    step(3);

    // Active-low ch2: pin low means pressed.
    bus.btn_in = 3'b000;
    step(9);
    chk_out("ch2 low c9", 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
    step(1);
    chk_out("ch2 press c10", 3'b100, 3'b100, 3'b000, 3'b000, 1'b1);
    bus.btn_in = 3'b100;
    step(10);
    chk_out("ch2 release", 3'b000, 3'b000, 3'b100, 3'b000, 1'b0);
    step(3);

    // Release landing on the long threshold cycle (cycle 42): release only.
    bus.btn_in = 3'b101;
    step(32);
    bus.btn_in = 3'b100;
    step(9);
    chk_out("thr c41", 3'b001, 3'b000, 3'b000, 3'b000, 1'b1);
    step(1);
    chk_out("thr c42 release wins", 3'b000, 3'b000, 3'b001, 3'b000, 1'b0);
    clr_acc();
    step_acc(15);
    chk_acc("thr after release", 3'b000, 3'b000, 3'b000);
    step(3);

    // Reset with ch1 HELD and ch0 at debounce count 5, both pins kept pressed.
    bus.btn_in = 3'b110;
    step(45);
    chk("ch1 held level", 32'(bus.btn_level), 32'(3'b010));
    bus.btn_in = 3'b111;
    step(7);
    reset = 1'b1;
    step(1);
    chk_out("mid reset", 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
    reset = 1'b0;
    clr_acc();
    step_acc(9);
    chk_acc("post reset r1..r9", 3'b000, 3'b000, 3'b000);
    chk("post reset level r9", 32'(bus.btn_level), 32'(3'b000));
    step(1);
    chk_out("post reset press r10", 3'b011, 3'b011, 3'b000, 3'b000, 1'b1);
    step(1);
    chk_out("post reset r11", 3'b011, 3'b000, 3'b000, 3'b000, 1'b1);
    step(30);
    chk_out("dual long r41", 3'b011, 3'b000, 3'b000, 3'b000, 1'b1);
    step(1);
    chk_out("dual long r42", 3'b011, 3'b000, 3'b000, 3'b011, 1'b1);
    bus.btn_in = 3'b100;
    step(12);
    chk_out("final idle", 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
